// File: rtl/fp2_result_unloader.sv
// rtl/fp2_result_unloader.sv - streams Fp/Fp2 result digits from the c_0/c_1 digit memories
// Reads are throttled so buffered plus in-flight digits never exceed the 2-entry skid buffer.
module fp2_result_unloader #(
  parameter int RADIX      = 32,
  parameter int DIGITS     = 14,
  parameter int DIGITS_LOG = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  extension_field_op,
  output logic                  mem_c_0_rd_en,
  output logic [DIGITS_LOG-1:0] mem_c_0_rd_addr,
  input  logic [RADIX-1:0]      mem_c_0_dout,
  output logic                  mem_c_1_rd_en,
  output logic [DIGITS_LOG-1:0] mem_c_1_rd_addr,
  input  logic [RADIX-1:0]      mem_c_1_dout,
  output logic                  m_valid,
  output logic [RADIX-1:0]      m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(2 * DIGITS + 1);
  localparam logic [DIGITS_LOG-1:0] ADDR_LAST = DIGITS_LOG'(DIGITS - 1);
  localparam logic [CNT_W-1:0]      XFER_LAST_FP  = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0]      XFER_LAST_FP2 = CNT_W'(2 * DIGITS - 1);

  typedef enum logic [1:0] {IDLE, RD0, RD1, DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  ext_q, ext_d;
  logic [DIGITS_LOG-1:0] addr_q, addr_d;
  logic [1:0]            count_q, count_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_sel_q, inflight_sel_d;
  logic [RADIX-1:0]      buf0_q, buf0_d;
  logic [RADIX-1:0]      buf1_q, buf1_d;
  logic [CNT_W-1:0]      xfer_q, xfer_d;
  logic                  done_q, done_d;

  logic                  pop;
  logic                  push;
  logic [RADIX-1:0]      din;
  logic [2:0]            occ;
  logic                  issue;
  logic                  last_xfer;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = RD0;
      RD0:   if (issue && addr_q == ADDR_LAST) state_d = ext_q ? RD1 : DRAIN;
      RD1:   if (issue && addr_q == ADDR_LAST) state_d = DRAIN;
      DRAIN: if (last_xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_valid         = (count_q != 2'd0);
    m_data          = buf0_q;
    m_last          = m_valid && (xfer_q == (ext_q ? XFER_LAST_FP2 : XFER_LAST_FP));
    pop             = m_valid && m_ready;
    last_xfer       = pop && m_last;
    occ             = {1'b0, count_q} + {2'b00, inflight_q};
    // A pop in this cycle frees a slot in time for the read issued now, keeping full rate.
    issue           = (state_q == RD0 || state_q == RD1) &&
                      ((occ < 3'd2) || (pop && occ == 3'd2));
    mem_c_0_rd_en   = issue && (state_q == RD0);
    mem_c_1_rd_en   = issue && (state_q == RD1);
    mem_c_0_rd_addr = addr_q;
    mem_c_1_rd_addr = addr_q;
    busy            = (state_q != IDLE);
    done            = done_q;
  end

  assign push = inflight_q;
  assign din  = inflight_sel_q ? mem_c_1_dout : mem_c_0_dout;

  always_comb begin
    ext_d          = ext_q;
    addr_d         = addr_q;
    xfer_d         = xfer_q;
    inflight_d     = issue;
    inflight_sel_d = (state_q == RD1);
    buf0_d         = buf0_q;
    buf1_d         = buf1_q;
    count_d        = count_q;
    done_d         = last_xfer;
    if (state_q == IDLE && start) begin
      ext_d  = extension_field_op;
      addr_d = '0;
      xfer_d = '0;
    end
    if (issue) addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
    if (pop)   xfer_d = xfer_q + 1'b1;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) buf0_d = din;
        else                 buf1_d = din;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        buf0_d  = buf1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          buf0_d = din;
        end else begin
          buf0_d = buf1_q;
          buf1_d = din;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_q          <= 1'b0;
      addr_q         <= '0;
      xfer_q         <= '0;
      inflight_q     <= 1'b0;
      inflight_sel_q <= 1'b0;
      buf0_q         <= '0;
      buf1_q         <= '0;
      count_q        <= 2'd0;
      done_q         <= 1'b0;
    end else begin
      ext_q          <= ext_d;
      addr_q         <= addr_d;
      xfer_q         <= xfer_d;
      inflight_q     <= inflight_d;
      inflight_sel_q <= inflight_sel_d;
      buf0_q         <= buf0_d;
      buf1_q         <= buf1_d;
      count_q        <= count_d;
      done_q         <= done_d;
    end
  end

endmodule

// File: tb/tb_fp2_result_unloader.sv
// tb/tb_fp2_result_unloader.sv - directed self-checking bench for fp2_result_unloader
module tb_fp2_result_unloader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        extension_field_op = 1'b0;
  logic        m_ready = 1'b0;
  logic        r0, r1;
  logic [3:0]  a0, a1;
  logic [31:0] d0, d1;
  logic        m_valid, m_last, busy, done;
  logic [31:0] m_data;

  logic [31:0] c0 [16];
  logic [31:0] c1 [16];

  int checks = 0;
  int errors = 0;

  logic [31:0] got [$];
  logic        lasts [$];
  int          rd_cnt = 0;
  int          done_cnt = 0;
  int          viol = 0;
  logic        seen13 = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;

  always #5 clk = ~clk;

  fp2_result_unloader dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .extension_field_op (extension_field_op),
    .mem_c_0_rd_en      (r0),
    .mem_c_0_rd_addr    (a0),
    .mem_c_0_dout       (d0),
    .mem_c_1_rd_en      (r1),
    .mem_c_1_rd_addr    (a1),
    .mem_c_1_dout       (d1),
    .m_valid            (m_valid),
    .m_data             (m_data),
    .m_last             (m_last),
    .m_ready            (m_ready),
    .busy               (busy),
    .done               (done)
  );

  always @(posedge clk) begin
    if (r0) d0 <= c0[a0];
    if (r1) d1 <= c1[a1];
  end

  // Stream collector and protocol watcher; the initial block reads its results #1 after negedge.
  always @(negedge clk) begin : mon
    int   n_rd, n_done, n_viol;
    logic s13;
    n_rd   = rd_cnt;
    n_done = done_cnt;
    n_viol = viol;
    s13    = seen13;
    if (rst) begin
      if (start && !busy) begin
        got.delete();
        lasts.delete();
        n_rd   = 0;
        n_done = 0;
        s13    = 1'b0;
      end
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        lasts.push_back(m_last);
      end
      if (r0) begin
        n_rd++;
        if (a0 == 4'd13) s13 = 1'b1;
      end
      if (r1) begin
        n_rd++;
        if (!s13) n_viol++;
      end
      if (n_rd - int'(got.size()) > 2) n_viol++;
      if (stall_prev && (!m_valid || m_data !== stall_data)) n_viol++;
      if (done) n_done++;
    end
    rd_cnt     <= n_rd;
    done_cnt   <= n_done;
    viol       <= n_viol;
    seen13     <= s13;
    stall_prev <= rst && m_valid && !m_ready;
    stall_data <= m_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_m_valid"}, {31'd0, m_valid}, 32'd0);
    chk({tag, "_m_data"},  m_data, 32'd0);
    chk({tag, "_m_last"},  {31'd0, m_last}, 32'd0);
    chk({tag, "_busy"},    {31'd0, busy}, 32'd0);
    chk({tag, "_done"},    {31'd0, done}, 32'd0);
    chk({tag, "_rd_en"},   {30'd0, r1, r0}, 32'd0);
    chk({tag, "_rd_addr"}, {24'd0, a1, a0}, 32'd0);
  endtask

  // mode: 0 ready=1, 1 random ready, 2 stall 20 cycles, 3 restart at transfer 5, 4 reset at transfer 7
  task automatic run(input logic e, input int mode, output int fv, output int dc);
    bit fired;
    fired = 1'b0;
    fv = -1;
    dc = -1;
    @(posedge clk); #1;
    start = 1'b1;
    extension_field_op = e;
    m_ready = (mode != 2);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (fv < 0 && m_valid) fv = k;
      if (done) begin
        dc = k;
        break;
      end
      if (mode == 4 && got.size() == 7) begin
        rst = 1'b0;
        #1;
        check_outputs_zero("midrst");
        return;
      end
      if (mode == 2 && fv >= 0 && k == fv + 20) chk("stall_reads", rd_cnt, 32'd2);
      @(posedge clk); #1;
      start = (mode == 3) && !fired && (got.size() == 5);
      fired = fired | start;
      if (mode == 1) m_ready = 1'($urandom_range(0, 1));
      if (mode == 2) m_ready = (fv >= 0) && (k >= fv + 20);
    end
    if (mode != 4) chk("timeout", {31'd0, dc >= 0}, 32'd1);
  endtask

  task automatic check_stream(input string tag, input int n, input logic [31:0] b0, input logic [31:0] b1);
    logic [31:0] exp;
    chk({tag, "_len"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      exp = (i < 14) ? b0 + i : b1 + (i - 14);
      chk($sformatf("%s_data%0d", tag, i), got[i], exp);
      chk($sformatf("%s_last%0d", tag, i), {31'd0, lasts[i]}, {31'd0, i == n - 1});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int fv, dc;
    for (int i = 0; i < 16; i++) begin
      c0[i] = 32'h1000 + i;
      c1[i] = 32'h0;
    end
    #12;
    check_outputs_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    idle(2);

    run(1'b0, 0, fv, dc);
    chk("fp_first_valid", fv, 32'd2);
    chk("fp_done_cycle", dc, 32'd16);
    check_stream("fp", 14, 32'h1000, 32'h0);
    idle(4);
    chk("fp_done_count", done_cnt, 32'd1);
    chk("fp_busy_after", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      c0[i] = i;
      c1[i] = 32'h80 + i;
    end
    run(1'b1, 0, fv, dc);
    chk("fp2_first_valid", fv, 32'd2);
    chk("fp2_done_cycle", dc, 32'd30);
    check_stream("fp2", 28, 32'h0, 32'h80);
    idle(4);
    chk("fp2_done_count", done_cnt, 32'd1);
    chk("fp2_protocol", viol, 32'd0);

    run(1'b1, 1, fv, dc);
    check_stream("bp", 28, 32'h0, 32'h80);
    idle(4);
    chk("bp_done_count", done_cnt, 32'd1);
    chk("bp_protocol", viol, 32'd0);

    for (int i = 0; i < 16; i++) c0[i] = 32'h2000 + i;
    run(1'b0, 2, fv, dc);
    check_stream("stall", 14, 32'h2000, 32'h0);
    idle(4);
    chk("stall_protocol", viol, 32'd0);

    for (int i = 0; i < 16; i++) c0[i] = 32'h1000 + i;
    run(1'b0, 3, fv, dc);
    chk("restart_done_cycle", dc, 32'd16);
    idle(20);
    chk("restart_done_count", done_cnt, 32'd1);
    check_stream("restart", 14, 32'h1000, 32'h0);
    chk("restart_busy", {31'd0, busy}, 32'd0);

    run(1'b0, 4, fv, dc);
    idle(3);
    rst = 1'b1;
    idle(3);
    chk("midrst_no_done", done_cnt, 32'd0);
    chk("midrst_idle", {31'd0, busy}, 32'd0);
    run(1'b0, 0, fv, dc);
    chk("postrst_first_valid", fv, 32'd2);
    chk("postrst_done_cycle", dc, 32'd16);
    check_stream("postrst", 14, 32'h1000, 32'h0);
    idle(4);
    chk("final_protocol", viol, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
